spi_txn_ctrl: RTL and testbench

Multi-byte transaction sequencer that sits directly upstream of the byte-level SPI master. It buffers TX bytes in a FIFO and feeds them one at a time over the master's TX_Byte / TX_DataValid / TX_Ready handshake. It also collects every RX_DataValid byte into an RX FIFO and owns the active-low chip select, with programmable setup and hold times, around a whole burst.

---
 rtl/spi_txn_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_txn_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_ctrl.sv
// rtl/spi_txn_ctrl.sv - SPI multi-byte transaction sequencer with TX/RX FIFOs and CS_n timing
// Optional feature macro: SPI_BYTE_GAP_EN (inserts GAP_CLKS idle cycles between bytes of a burst)

// Byte FIFO with first-word fall-through head; extra pointer MSB distinguishes full from empty.
module spi_txn_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop are both judged against the pre-cycle full/empty state.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge Clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module spi_txn_ctrl #(
  parameter int FIFO_DEPTH    = 8,
  parameter int LEN_W         = 4,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int GAP_CLKS      = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  output logic             tx_full,
  input  logic             start,
  input  logic [LEN_W-1:0] txn_len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_data,
  input  logic             rd_en,
  output logic             rx_empty,
  output logic             rx_overflow,
  output logic [7:0]       TX_Byte,
  output logic             TX_DataValid,
  input  logic             TX_Ready,
  input  logic             RX_DataValid,
  input  logic [7:0]       RX_Byte,
  output logic             SPI_CS_n
);
  // Counter is shared by setup, hold and gap phases, so size it for the longest one.
  localparam int CNT_MAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int CNT_MAX    = (CNT_MAX_SH > GAP_CLKS) ? CNT_MAX_SH : GAP_CLKS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [LEN_W:0]   REM_ONE    = (LEN_W+1)'(1);
  // The send decision is registered, so the last setup cycle already issues the byte.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
  // Entering CS_HOLD already consumes one cycle after the final RX_DataValid.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((CS_HOLD_CLKS >= 2) ? CS_HOLD_CLKS - 2 : 0);
`ifdef SPI_BYTE_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CLKS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND,
    WAIT_RX,
`ifdef SPI_BYTE_GAP_EN
    GAP,
`endif
    CS_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W:0]   rem;
  logic             dv_d;

  logic [7:0] tx_head;
  logic       tx_empty;
  logic       rx_full;
  logic       send_window;
  logic       send_now;
  logic       rx_push;

  // TX_Ready is ignored while the pulse and the following cycle are in flight.
  assign send_window = (state == SEND) || ((state == CS_SETUP) && (cnt == SETUP_LAST));
  assign send_now    = send_window && TX_Ready && !tx_empty && !TX_DataValid && !dv_d;
  assign rx_push     = (state == WAIT_RX) && RX_DataValid;

  spi_txn_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .Clk       (Clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (send_now),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  spi_txn_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .Clk       (Clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (RX_Byte),
    .pop       (rd_en),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Burst sequencer: chip select framing, byte issue, RX collection and completion pulse.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      dv_d         <= 1'b0;
      SPI_CS_n     <= 1'b1;
      TX_DataValid <= 1'b0;
      TX_Byte      <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_overflow  <= 1'b0;
    end else begin
      TX_DataValid <= 1'b0;
      done         <= 1'b0;
      dv_d         <= TX_DataValid;
      case (state)
        IDLE: begin
          if (start) begin
            rem         <= {1'b0, txn_len} + REM_ONE;
            rx_overflow <= 1'b0;
            busy        <= 1'b1;
            SPI_CS_n    <= 1'b0;
            cnt         <= '0;
            state       <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (send_now) begin
            TX_Byte      <= tx_head;
            TX_DataValid <= 1'b1;
            state        <= WAIT_RX;
          end else if (cnt == SETUP_LAST) begin
            state <= SEND;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SEND: begin
          if (send_now) begin
            TX_Byte      <= tx_head;
            TX_DataValid <= 1'b1;
            state        <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (RX_DataValid) begin
            if (rx_full) rx_overflow <= 1'b1;
            rem <= rem - REM_ONE;
            cnt <= '0;
            if (rem == REM_ONE) begin
              if (CS_HOLD_CLKS == 1) begin
                SPI_CS_n <= 1'b1;
                done     <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                state <= CS_HOLD;
              end
            end else begin
`ifdef SPI_BYTE_GAP_EN
              state <= GAP;
`else
              state <= SEND;
`endif
            end
          end
        end
`ifdef SPI_BYTE_GAP_EN
        GAP: begin
          if (cnt == GAP_LAST) state <= SEND;
          else cnt <= cnt + CNT_ONE;
        end
`endif
        CS_HOLD: begin
          if (cnt == HOLD_LAST) begin
            SPI_CS_n <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb/tb_spi_txn_ctrl.sv - directed self-checking bench for spi_txn_ctrl
module tb_spi_txn_ctrl;
  logic       Clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       tx_full;
  logic       start;
  logic [3:0] txn_len;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       rx_empty;
  logic       rx_overflow;
  logic [7:0] TX_Byte;
  logic       TX_DataValid;
  logic       TX_Ready;
  logic       RX_DataValid;
  logic [7:0] RX_Byte;
  logic       SPI_CS_n;

  int checks = 0;
  int errors = 0;

`ifdef SPI_BYTE_GAP_EN
  localparam int EXP_B2B = 2 + 4;
`else
  localparam int EXP_B2B = 2;
`endif

  logic [7:0] slave_q[$];
  logic [7:0] tx_bytes[$];
  int tx_times[$];
  int rxdv_times[$];
  int cs_fall_times[$];
  int cs_rise_times[$];
  int done_cnt;
  int cyc;
  int mst_cnt;
  logic prev_cs;

  spi_txn_ctrl dut (
    .Clk(Clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .tx_full(tx_full),
    .start(start), .txn_len(txn_len), .busy(busy), .done(done), .rx_data(rx_data),
    .rd_en(rd_en), .rx_empty(rx_empty), .rx_overflow(rx_overflow), .TX_Byte(TX_Byte),
    .TX_DataValid(TX_DataValid), .TX_Ready(TX_Ready), .RX_DataValid(RX_DataValid),
    .RX_Byte(RX_Byte), .SPI_CS_n(SPI_CS_n)
  );

  always #5 Clk = ~Clk;

  // Byte-level SPI master model plus event monitor, all timed in negedges.
  initial begin
    TX_Ready = 1'b1; RX_DataValid = 1'b0; RX_Byte = 8'h00;
    mst_cnt = 0; cyc = 0; done_cnt = 0; prev_cs = 1'b1;
    forever begin
      @(negedge Clk);
      cyc++;
      RX_DataValid = 1'b0;
      if (prev_cs === 1'b1 && SPI_CS_n === 1'b0) cs_fall_times.push_back(cyc);
      if (prev_cs === 1'b0 && SPI_CS_n === 1'b1) cs_rise_times.push_back(cyc);
      prev_cs = SPI_CS_n;
      if (done === 1'b1) done_cnt++;
      if (reset) begin
        mst_cnt = 0;
        TX_Ready = 1'b1;
      end else if (mst_cnt == 0) begin
        if (TX_DataValid === 1'b1) begin
          tx_bytes.push_back(TX_Byte);
          tx_times.push_back(cyc);
          mst_cnt = 1;
        end
      end else begin
        mst_cnt++;
        if (mst_cnt == 2) TX_Ready = 1'b0;
        if (mst_cnt == 8) begin
          RX_Byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF;
          RX_DataValid = 1'b1;
          rxdv_times.push_back(cyc);
          TX_Ready = 1'b1;
          mst_cnt = 0;
        end
      end
    end
  end

  task automatic clear_logs();
    tx_bytes.delete(); tx_times.delete(); rxdv_times.delete();
    cs_fall_times.delete(); cs_rise_times.delete(); slave_q.delete();
    done_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge Clk);
    wr_data = b; wr_en = 1'b1;
    @(negedge Clk);
    wr_en = 1'b0;
  endtask

  task automatic start_burst(input logic [3:0] len);
    @(negedge Clk);
    start = 1'b1; txn_len = len;
    @(negedge Clk);
    start = 1'b0;
    checks++;
    if (SPI_CS_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_to_cs: cs_n=%b busy=%b, required cs_n=0 busy=1", SPI_CS_n, busy);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, limit);
    end
    @(negedge Clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    checks++;
    if (rx_empty !== 1'b0 || rx_data !== exp) begin
      errors++;
      $display("FAIL %s: rx_empty=%b rx_data=%h, required rx_empty=0 rx_data=%h", name, rx_empty, rx_data, exp);
    end
    rd_en = 1'b1;
    @(negedge Clk);
    rd_en = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    check_bit("rst_cs_n", SPI_CS_n, 1'b1);
    check_bit("rst_tx_dv", TX_DataValid, 1'b0);
    check_int("rst_tx_byte", int'(TX_Byte), 0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_rx_overflow", rx_overflow, 1'b0);
    check_bit("rst_tx_full", tx_full, 1'b0);
    check_bit("rst_rx_empty", rx_empty, 1'b1);
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    check_bit("post_rst_cs_n", SPI_CS_n, 1'b1);
  endtask

  task automatic test_basic_burst();
    clear_logs();
    push_byte(8'hA5);
    push_byte(8'h3C);
    slave_q.push_back(8'h5A);
    slave_q.push_back(8'hC3);
    start_burst(4'd1);
    wait_idle("basic", 200);
    check_int("basic_tx_count", tx_bytes.size(), 2);
    check_int("basic_tx0", int'(tx_bytes[0]), 8'hA5);
    check_int("basic_tx1", int'(tx_bytes[1]), 8'h3C);
    check_int("basic_done_cnt", done_cnt, 1);
    check_int("basic_cs_falls", cs_fall_times.size(), 1);
    check_int("basic_cs_rises", cs_rise_times.size(), 1);
    check_int("basic_setup_lat", tx_times[0] - cs_fall_times[0], 2);
    check_int("basic_b2b_lat", tx_times[1] - rxdv_times[0], EXP_B2B);
    check_int("basic_hold_lat", cs_rise_times[0] - rxdv_times[1], 2);
    pop_check("basic_rx0", 8'h5A);
    pop_check("basic_rx1", 8'hC3);
    check_bit("basic_rx_empty", rx_empty, 1'b1);
  endtask

  task automatic test_underrun();
    clear_logs();
    push_byte(8'h11);
    slave_q.push_back(8'h21);
    slave_q.push_back(8'h22);
    slave_q.push_back(8'h23);
    start_burst(4'd2);
    repeat (40) @(negedge Clk);
    check_int("stall_tx_count", tx_bytes.size(), 1);
    check_bit("stall_cs_low", SPI_CS_n, 1'b0);
    check_bit("stall_busy", busy, 1'b1);
    push_byte(8'h12);
    push_byte(8'h13);
    wait_idle("underrun", 200);
    check_int("resume_tx_count", tx_bytes.size(), 3);
    check_int("resume_tx2", int'(tx_bytes[2]), 8'h13);
    check_int("resume_done_cnt", done_cnt, 1);
    check_int("resume_cs_rises", cs_rise_times.size(), 1);
    pop_check("resume_rx0", 8'h21);
    pop_check("resume_rx1", 8'h22);
    pop_check("resume_rx2", 8'h23);
  endtask

  task automatic test_overflow();
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      push_byte(8'h80 + 8'(i));
      slave_q.push_back(8'h90 + 8'(i));
    end
    check_bit("tx_full_at_depth", tx_full, 1'b1);
    push_byte(8'h99);
    start_burst(4'd7);
    wait_idle("fill", 400);
    check_int("fill_tx_count", tx_bytes.size(), 8);
    check_int("fill_tx7", int'(tx_bytes[7]), 8'h87);
    check_bit("fill_no_overflow", rx_overflow, 1'b0);
    clear_logs();
    push_byte(8'h55);
    slave_q.push_back(8'hEE);
    start_burst(4'd0);
    wait_idle("ovf", 200);
    check_int("ovf_tx0_full_push_dropped", int'(tx_bytes[0]), 8'h55);
    check_bit("ovf_set", rx_overflow, 1'b1);
    check_int("ovf_done_cnt", done_cnt, 1);
    for (int i = 0; i < 8; i++) pop_check("ovf_rx_kept", 8'h90 + 8'(i));
    check_bit("ovf_rx_empty", rx_empty, 1'b1);
    clear_logs();
    push_byte(8'h56);
    slave_q.push_back(8'h66);
    start_burst(4'd0);
    check_bit("ovf_cleared_on_start", rx_overflow, 1'b0);
    wait_idle("ovf_clear", 200);
    pop_check("ovf_next_rx", 8'h66);
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      push_byte(8'h40 + 8'(i));
      slave_q.push_back(8'h30 + 8'(i));
    end
    start_burst(4'd7);
    while ((rxdv_times.size() < 1 || tx_bytes.size() < 2) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check_int("mid_second_byte_sent", tx_bytes.size(), 2);
    push_byte(8'hB0);
    push_byte(8'hB1);
    check_bit("mid_tx_full", tx_full, 1'b1);
    check_bit("mid_rx_nonempty", rx_empty, 1'b0);
    reset = 1'b1;
    #1;
    check_bit("mid_rst_cs_n", SPI_CS_n, 1'b1);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_rx_empty", rx_empty, 1'b1);
    check_bit("mid_rst_tx_full", tx_full, 1'b0);
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    clear_logs();
    push_byte(8'h77);
    slave_q.push_back(8'h88);
    start_burst(4'd0);
    wait_idle("post_rst", 200);
    check_int("post_rst_tx_count", tx_bytes.size(), 1);
    check_int("post_rst_tx0", int'(tx_bytes[0]), 8'h77);
    check_int("post_rst_done_cnt", done_cnt, 1);
    pop_check("post_rst_rx0", 8'h88);
  endtask

`ifdef SPI_BYTE_GAP_EN
  task automatic test_gap();
    clear_logs();
    push_byte(8'h01);
    push_byte(8'h02);
    slave_q.push_back(8'h03);
    slave_q.push_back(8'h04);
    start_burst(4'd1);
    wait_idle("gap", 200);
    checks++;
    if (tx_times[1] - rxdv_times[0] < 5) begin
      errors++;
      $display("FAIL gap_idle: rxdv-to-txdv %0d cycles, required >= 5", tx_times[1] - rxdv_times[0]);
    end
    pop_check("gap_rx0", 8'h03);
    pop_check("gap_rx1", 8'h04);
  endtask
`endif

  initial begin
    reset = 1'b1; wr_data = 8'h00; wr_en = 1'b0; start = 1'b0;
    txn_len = 4'd0; rd_en = 1'b0;
    repeat (3) @(negedge Clk);
    test_reset();
    test_basic_burst();
    test_underrun();
    test_overflow();
    test_reset_mid_burst();
`ifdef SPI_BYTE_GAP_EN
    test_gap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
